// File: rtl/dma_rd_sram.sv
// DMA read consumer: takes the address stream, reads a fixed-latency SRAM, and returns an in-order data stream.
// Optional framing checker is enabled by defining DMA_RD_FRAME_CHK_EN.
module dma_rd_sram #(
    parameter int AW    = 14,
    parameter int DW    = 32,
    parameter int IFW   = 4,
    parameter int RL    = 1,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [AW-1:0]  m_addr,
    input  logic [IFW-1:0] m_info,
    input  logic           m_first,
    input  logic           m_last,
    input  logic           m_valid,
    output logic           m_ready,
    output logic           mem_cs,
    output logic [AW-1:0]  mem_addr,
    input  logic [DW-1:0]  mem_rdata,
    output logic [DW-1:0]  d_data,
    output logic [IFW-1:0] d_info,
    output logic           d_first,
    output logic           d_last,
    output logic           d_valid,
    input  logic           d_ready,
    output logic           frame_err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = IFW + 2;

    logic [CW-1:0]    used;
    logic [CW-1:0]    count;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             accept;
    logic             pop;
    logic             push;
    logic             pipe_vld [RL];
    logic [SW-1:0]    pipe_sb  [RL];
    logic [DW+SW-1:0] fifo_mem [DEPTH];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A read is only issued when a buffer slot is already reserved for its data.
    assign m_ready  = (used < CW'(DEPTH));
    assign accept   = m_valid & m_ready;
    assign pop      = d_valid & d_ready;
    assign push     = pipe_vld[RL-1];
    assign mem_cs   = accept;
    assign mem_addr = m_addr;
    assign d_valid  = (count != '0);
    assign {d_data, d_info, d_first, d_last} = fifo_mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            used <= '0;
        end else if (accept && !pop) begin
            used <= used + 1'b1;
        end else if (pop && !accept) begin
            used <= used - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RL; i++) pipe_vld[i] <= 1'b0;
        end else begin
            pipe_vld[0] <= accept;
            for (int i = 1; i < RL; i++) pipe_vld[i] <= pipe_vld[i-1];
        end
    end

    // Sideband payload needs no reset; only the valid bits qualify it.
    always_ff @(posedge clk) begin
        pipe_sb[0] <= {m_info, m_first, m_last};
        for (int i = 1; i < RL; i++) pipe_sb[i] <= pipe_sb[i-1];
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {mem_rdata, pipe_sb[RL-1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

`ifdef DMA_RD_FRAME_CHK_EN
    logic in_frame;
    logic frame_err_q;

    // A first beat must open a frame and every other beat must fall inside one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_frame    <= 1'b0;
            frame_err_q <= 1'b0;
        end else if (accept) begin
            if (m_first == in_frame) frame_err_q <= 1'b1;
            if (m_last) begin
                in_frame <= 1'b0;
            end else if (m_first) begin
                in_frame <= 1'b1;
            end
        end
    end

    assign frame_err = frame_err_q;
`else
    assign frame_err = 1'b0;
`endif

endmodule
